// File: rtl/percent_pkg.sv
// Shared types and sizes for the percentage-divider arbiter.
package percent_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   localparam int PCT_W          = 20;
   localparam int PCT_RW         = 7;
   localparam int PCT_MAX_CYCLES = 256;

endpackage

// File: rtl/percent_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic          any,
   output logic [LW-1:0] g
);

   logic [LW:0] s;

   // One extra bit so last+i never overflows before the explicit wrap
   always_comb begin
      any = 1'b0;
      g   = '0;
      s   = '0;
      for (int i = 1; i <= N; i++) begin
         s = {1'b0, last} + (LW+1)'(i);
         if (s >= (LW+1)'(N)) s = s - (LW+1)'(N);
         if (!any && req[s[LW-1:0]]) begin
            any = 1'b1;
            g   = s[LW-1:0];
         end
      end
   end

endmodule

// File: rtl/percent_arbiter.sv
// Shares one Percentage divider among N_REQ requesters, round-robin,
// with a watchdog that answers err=1 if the divider never finishes.
module percent_arbiter
   import percent_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = PCT_W,
   parameter int RW      = PCT_RW,
   parameter int TIMEOUT = 300
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] num,
   input  logic [N_REQ*W-1:0] den,
   output logic [N_REQ-1:0]   ack,
   output logic [RW-1:0]      result,
   output logic               err,
   output logic               busy,
   output logic               pct_go,
   output logic [W-1:0]       pct_num,
   output logic [W-1:0]       pct_den,
   input  logic               pct_done,
   input  logic [RW-1:0]      pct_answer
);

   localparam int LW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT);

   arb_state_e        state_q, state_d;
   logic [LW-1:0]     last_q, last_d;
   logic [LW-1:0]     g_q, g_d;
   logic [TW-1:0]     wd_q, wd_d;
   logic [W-1:0]      num_q, num_d;
   logic [W-1:0]      den_q, den_d;
   logic              go_q, go_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [RW-1:0]     res_q, res_d;
   logic              err_q, err_d;
   logic              to_q, to_d;

   logic              any;
   logic [LW-1:0]     gp;

   rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
      .req  (req),
      .last (last_q),
      .any  (any),
      .g    (gp)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      g_d     = g_q;
      wd_d    = wd_q;
      num_d   = num_q;
      den_d   = den_q;
      go_d    = go_q;
      ack_d   = '0;
      res_d   = res_q;
      err_d   = err_q;
      to_d    = to_q;
      unique case (state_q)
         IDLE: begin
            // A divider still showing done must not see a new go
            if (any && !pct_done) begin
               num_d   = num[int'(gp)*W +: W];
               den_d   = den[int'(gp)*W +: W];
               g_d     = gp;
               wd_d    = '0;
               go_d    = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_d = wd_q + TW'(1);
            if (pct_done) begin
               res_d   = pct_answer;
               err_d   = 1'b0;
               to_d    = 1'b0;
               ack_d   = N_REQ'(1) << g_q;
               go_d    = 1'b0;
               last_d  = g_q;
               state_d = RELEASE;
            end else if (wd_q == TW'(TIMEOUT-1)) begin
               res_d   = '0;
               err_d   = 1'b1;
               to_d    = 1'b1;
               ack_d   = N_REQ'(1) << g_q;
               go_d    = 1'b0;
               last_d  = g_q;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (to_q || !pct_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= LW'(N_REQ-1);
         g_q     <= '0;
         wd_q    <= '0;
         num_q   <= '0;
         den_q   <= '0;
         go_q    <= 1'b0;
         ack_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         g_q     <= g_d;
         wd_q    <= wd_d;
         num_q   <= num_d;
         den_q   <= den_d;
         go_q    <= go_d;
         ack_q   <= ack_d;
         res_q   <= res_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign ack     = ack_q;
   assign result  = res_q;
   assign err     = err_q;
   assign busy    = (state_q != IDLE);
   assign pct_go  = go_q;
   assign pct_num = num_q;
   assign pct_den = den_q;

endmodule

// File: tb/tb_percent_arbiter.sv
// Directed bench for percent_arbiter with a behavioural divider model.
module tb_percent_arbiter;

   localparam int N   = 4;
   localparam int W   = 20;
   localparam int RW  = 7;
   localparam int TMO = 300;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] num, den;
   logic [N-1:0]   ack;
   logic [RW-1:0]  result;
   logic           err, busy, pct_go;
   logic [W-1:0]   pct_num, pct_den;
   logic           pct_done;
   logic [RW-1:0]  pct_answer;

   logic           dn_q = 1'b0;
   logic [RW-1:0]  ans_q = '0;
   int             cnt_q = 0;
   logic           stuck = 1'b0;
   logic           force_done = 1'b0;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   percent_arbiter #(.N_REQ(N), .W(W), .RW(RW), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .num        (num),
      .den        (den),
      .ack        (ack),
      .result     (result),
      .err        (err),
      .busy       (busy),
      .pct_go     (pct_go),
      .pct_num    (pct_num),
      .pct_den    (pct_den),
      .pct_done   (pct_done),
      .pct_answer (pct_answer)
   );

   function automatic int pct(input longint n, input longint d);
      longint q;
      if (d == 0) return 0;
      q = (100 * n + d - 1) / d;
      if (q > 127) q = 127;
      return int'(q);
   endfunction

   // Divider model: done after 2k+2 cycles of go, held until go drops
   always_ff @(posedge clk) begin
      if (!pct_go) begin
         dn_q  <= 1'b0;
         cnt_q <= 0;
      end else if (!dn_q && !stuck) begin
         if (cnt_q >= 2 * pct(pct_num, pct_den) + 2) begin
            dn_q  <= 1'b1;
            ans_q <= RW'(pct(pct_num, pct_den));
         end else begin
            cnt_q <= cnt_q + 1;
         end
      end
   end

   assign pct_done   = dn_q | force_done;
   assign pct_answer = ans_q;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int n, input int d);
      num[i*W +: W] = W'(n);
      den[i*W +: W] = W'(d);
   endtask

   task automatic wait_ack(input string tag, output int cyc);
      cyc = 0;
      while (ack == '0 && cyc < 2000) begin
         tick();
         cyc++;
      end
      if (ack == '0) check({tag, "_ack_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while (busy && c < 50) begin
         tick();
         c++;
      end
      check({tag, "_idle"}, 32'(busy), 0);
   endtask

   task automatic run_one(input string tag, input int i, input int n,
                          input int d, input int er);
      int cyc;
      set_op(i, n, d);
      req[i] = 1'b1;
      tick();
      check({tag, "_go_lat"}, 32'(pct_go), 1);
      wait_ack(tag, cyc);
      req[i] = 1'b0;
      check({tag, "_ack"}, 32'(ack), 32'(1 << i));
      check({tag, "_res"}, 32'(result), 32'(er));
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_go_low"}, 32'(pct_go), 0);
      tick();
      check({tag, "_ack_pulse"}, 32'(ack), 0);
      wait_idle(tag);
   endtask

   initial begin
      int cyc;
      int order[5];
      reset = 1'b0;
      req   = '0;
      num   = '0;
      den   = '0;
      #12;
      check("rst_ack", 32'(ack), 0);
      check("rst_res", 32'(result), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_go", 32'(pct_go), 0);
      check("rst_num", 32'(pct_num), 0);
      check("rst_den", 32'(pct_den), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      run_one("half", 0, 50, 100, 50);
      run_one("third", 1, 1, 3, 34);
      run_one("clamp", 2, 200, 100, 127);
      run_one("zero", 3, 7, 0, 0);

      // Fairness: restart from reset so requester 0 wins first
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      for (int i = 0; i < N; i++) set_op(i, 10 * (i + 1), 100);
      req = '1;
      for (int k = 0; k < 5; k++) begin
         wait_ack("fair", cyc);
         order[k] = -1;
         for (int i = 0; i < N; i++) if (ack[i]) order[k] = i;
         check("fair_res", 32'(result), 32'(10 * (order[k] + 1)));
         tick();
      end
      req = '0;
      check("fair_o0", 32'(order[0]), 0);
      check("fair_o1", 32'(order[1]), 1);
      check("fair_o2", 32'(order[2]), 2);
      check("fair_o3", 32'(order[3]), 3);
      check("fair_o4", 32'(order[4]), 0);
      wait_idle("fair");

      // Stuck divider: watchdog answer exactly TMO cycles after go
      stuck = 1'b1;
      set_op(2, 40, 100);
      req[2] = 1'b1;
      cyc = 0;
      while (!pct_go && cyc < 10) begin
         tick();
         cyc++;
      end
      check("wd_go", 32'(pct_go), 1);
      wait_ack("wd", cyc);
      req[2] = 1'b0;
      check("wd_cycles", 32'(cyc), TMO);
      check("wd_ack", 32'(ack), 32'(4));
      check("wd_err", 32'(err), 1);
      check("wd_res", 32'(result), 0);
      tick();
      check("wd_back_idle", 32'(busy), 0);
      stuck = 1'b0;
      tick();

      // Reset during LAUNCH while the divider still reports done
      set_op(0, 25, 100);
      req[0] = 1'b1;
      tick();
      tick();
      tick();
      check("mid_go", 32'(pct_go), 1);
      force_done = 1'b1;
      reset = 1'b0;
      #1;
      check("mid_go0", 32'(pct_go), 0);
      check("mid_busy0", 32'(busy), 0);
      check("mid_num0", 32'(pct_num), 0);
      check("mid_ack0", 32'(ack), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("guard_busy", 32'(busy), 0);
      check("guard_go", 32'(pct_go), 0);
      force_done = 1'b0;
      tick();
      tick();
      check("guard_grant", 32'(pct_go), 1);
      wait_ack("guard", cyc);
      req[0] = 1'b0;
      check("guard_res", 32'(result), 25);
      wait_idle("guard");

      // Operands captured at grant are immune to later changes
      set_op(1, 30, 60);
      req[1] = 1'b1;
      tick();
      check("cap_go", 32'(pct_go), 1);
      set_op(1, 90, 60);
      tick();
      check("cap_num", 32'(pct_num), 30);
      wait_ack("cap", cyc);
      req[1] = 1'b0;
      check("cap_ack", 32'(ack), 32'(2));
      check("cap_res", 32'(result), 50);
      wait_idle("cap");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
